player_check: RTL and testbench

PLAYER_CHECK -- requirements
Module: player_check

---
 rtl/player_check.sv | 126 ++++++++++++
 tb/tb_player_check.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/player_check.sv
// Checks a player's button presses against a stored colour sequence, one entry per
// press/release pair, with a per-entry press timeout. All outputs are registered.
module player_check #(
    parameter int TIMEOUT = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       round_len,
    input  logic [31:0][2:0] segment,
    input  logic [3:0]       player_input,
    output logic [4:0]       check_round,
    output logic             busy,
    output logic             accepted,
    output logic             pass,
    output logic             fail
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [4:0]      round_n;
    logic            busy_n, acc_n, pass_n, fail_n;

    logic [2:0]      code;
    logic            one_hot;
    logic            is_match;
    logic            len_ok;
    logic            last_entry;

    assign code       = segment[check_round];
    assign one_hot    = (player_input != 4'd0) && ((player_input & (player_input - 4'd1)) == 4'd0);
    // Codes 4..7 never match, so any press against them is a miss.
    assign is_match   = !code[2] && (player_input == (4'b0001 << code[1:0]));
    assign len_ok     = (round_len != 6'd0) && (round_len <= 6'd32);
    assign last_entry = (({1'b0, check_round} + 6'd1) == round_len);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            check_round <= 5'd0;
            timer       <= '0;
            busy        <= 1'b0;
            accepted    <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_n;
            check_round <= round_n;
            timer       <= timer_n;
            busy        <= busy_n;
            accepted    <= acc_n;
            pass        <= pass_n;
            fail        <= fail_n;
        end
    end

    always_comb begin
        state_n = state;
        round_n = check_round;
        timer_n = timer;
        busy_n  = busy;
        acc_n   = 1'b0;
        pass_n  = 1'b0;
        fail_n  = 1'b0;

        case (state)
            IDLE: begin
                if (start && len_ok) begin
                    state_n = WAIT_PRESS;
                    round_n = 5'd0;
                    timer_n = '0;
                    busy_n  = 1'b1;
                end
            end

            WAIT_PRESS: begin
                if (player_input == 4'd0) begin
                    if (timer == T_LAST) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        fail_n  = 1'b1;
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end else if (one_hot && is_match) begin
                    state_n = WAIT_RELEASE;
                end else begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    fail_n  = 1'b1;
                end
            end

            WAIT_RELEASE: begin
                // Any held pattern is ignored here; only full release advances.
                if (player_input == 4'd0) begin
                    acc_n = 1'b1;
                    if (last_entry) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        pass_n  = 1'b1;
                    end else begin
                        state_n = WAIT_PRESS;
                        round_n = check_round + 5'd1;
                        timer_n = '0;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_player_check.sv
// Scoreboard bench for player_check: stimulus queues expected pulse events and a
// negedge monitor compares every accepted/pass/fail pulse against the queue.
module tb_player_check;

    logic             clk;
    logic             reset;
    logic             start;
    logic [5:0]       round_len;
    logic [31:0][2:0] segment;
    logic [3:0]       player_input;
    logic [4:0]       check_round;
    logic             busy;
    logic             accepted;
    logic             pass;
    logic             fail;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       acc;
        logic       pas;
        logic       fl;
        logic [4:0] idx;
        logic       bsy;
    } ev_t;

    ev_t exp_q[$];

    player_check #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .round_len    (round_len),
        .segment      (segment),
        .player_input (player_input),
        .check_round  (check_round),
        .busy         (busy),
        .accepted     (accepted),
        .pass         (pass),
        .fail         (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    function automatic ev_t mk(logic a, logic p, logic f, logic [4:0] i, logic b);
        ev_t e;
        e.acc = a; e.pas = p; e.fl = f; e.idx = i; e.bsy = b;
        return e;
    endfunction

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && (accepted || pass || fail)) begin
            ev_t act;
            act = mk(accepted, pass, fail, check_round, busy);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got acc=%0b pass=%0b fail=%0b idx=%0d busy=%0b, none expected",
                         act.acc, act.pas, act.fl, act.idx, act.bsy);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL pulse_event: got acc=%0b pass=%0b fail=%0b idx=%0d busy=%0b, want acc=%0b pass=%0b fail=%0b idx=%0d busy=%0b",
                             act.acc, act.pas, act.fl, act.idx, act.bsy, e.acc, e.pas, e.fl, e.idx, e.bsy);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [5:0] len);
        round_len = len;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic press(input logic [3:0] bits);
        player_input = bits;
        tick();
    endtask

    // Press then release one entry, queuing the accepted (and pass when last) pulse.
    task automatic play_entry(input logic [3:0] bits, input int idx, input int len);
        press(bits);
        if (idx + 1 == len) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 5'(idx), 1'b0));
        else                exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 5'(idx + 1), 1'b1));
        player_input = 4'd0;
        tick();
    endtask

    task automatic drain();
        repeat (3) tick();
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        start = 1'b0;
        round_len = 6'd0;
        segment = '0;
        player_input = 4'd0;
        repeat (2) tick();
        check("reset_busy", busy, 0);
        check("reset_check_round", check_round, 0);
        check("reset_accepted", accepted, 0);
        check("reset_pass", pass, 0);
        check("reset_fail", fail, 0);
        reset = 1'b0;
        tick();

        // Three-entry round 0,3,1
        segment[0] = 3'd0; segment[1] = 3'd3; segment[2] = 3'd1;
        do_start(6'd3);
        check("busy_after_start", busy, 1);
        play_entry(4'b0001, 0, 3);
        play_entry(4'b1000, 1, 3);
        play_entry(4'b0010, 2, 3);
        tick();
        check("round3_busy", busy, 0);
        check("round3_check_round", check_round, 2);

        // Wrong single press
        segment[0] = 3'd2;
        do_start(6'd1);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 5'd0, 1'b0));
        press(4'b0001);
        player_input = 4'd0;
        drain();
        check("wrong_press_check_round", check_round, 0);
        check("wrong_press_busy", busy, 0);

        // Two buttons at once
        do_start(6'd1);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 5'd0, 1'b0));
        press(4'b0101);
        player_input = 4'd0;
        drain();

        // Invalid colour code
        segment[0] = 3'd5;
        do_start(6'd1);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 5'd0, 1'b0));
        press(4'b0010);
        player_input = 4'd0;
        drain();

        // Timeout: fail exactly 16 cycles after busy rises
        segment[0] = 3'd0;
        do_start(6'd1);
        check("timeout_busy_rise", busy, 1);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 5'd0, 1'b0));
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (fail) break;
            cnt++;
        end
        check("timeout_cycles", cnt, 16);
        drain();

        // Press on the last timer cycle wins; no timeout while held
        do_start(6'd1);
        repeat (15) tick();
        press(4'b0001);
        repeat (20) tick();
        check("held_busy", busy, 1);
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 5'd0, 1'b0));
        player_input = 4'd0;
        tick();
        drain();

        // Invalid lengths are ignored
        do_start(6'd0);
        drain();
        check("len0_busy", busy, 0);
        do_start(6'd33);
        drain();
        check("len33_busy", busy, 0);

        // Start while busy has no effect
        segment[0] = 3'd0; segment[1] = 3'd1;
        do_start(6'd2);
        play_entry(4'b0001, 0, 2);
        do_start(6'd2);
        check("restart_ignored_idx", check_round, 1);
        play_entry(4'b0010, 1, 2);
        drain();
        check("restart_final_idx", check_round, 1);

        // Reset in WAIT_RELEASE at index 4
        for (int i = 0; i < 32; i++) segment[i] = 3'(i % 4);
        do_start(6'd5);
        for (int i = 0; i < 4; i++) play_entry(4'(1 << (i % 4)), i, 5);
        press(4'(1 << 0));
        check("pre_reset_idx", check_round, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_check_round", check_round, 0);
        check("abort_pass", pass, 0);
        check("abort_fail", fail, 0);
        player_input = 4'd0;
        drain();

        // Full 32-entry round
        do_start(6'd32);
        for (int i = 0; i < 32; i++) play_entry(4'(1 << (i % 4)), i, 32);
        drain();
        check("len32_check_round", check_round, 31);
        check("len32_busy", busy, 0);

        drain();
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
